// File: rtl/cnn_pkg.sv
// Shared constants and controller state encoding for the CNN inference host logic.
package cnn_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int FRAC_WIDTH  = 8;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        SCAN,
        HOLD
    } ctrl_state_t;
endpackage

// File: rtl/cnn_argmax_seq.sv
// Snapshot of the accelerator scores plus a one-entry-per-cycle signed argmax scan.
module cnn_argmax_seq #(
    parameter int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load,
    input  logic                              step,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] predictions,
    output logic                              last,
    output logic [3:0]                        best_idx,
    output logic signed [DATA_WIDTH-1:0]      best_val
);
    import cnn_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    logic signed [DATA_WIDTH-1:0] pred_word [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] snap_reg  [NUM_CLASSES];
    logic [3:0]                   scan_idx_reg;
    logic [3:0]                   best_idx_reg;
    logic signed [DATA_WIDTH-1:0] best_val_reg;
    logic signed [DATA_WIDTH-1:0] cand;
    logic                         take;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
            assign pred_word[gi] = predictions[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Outputs already merge the entry under the scan pointer, so the parent can
    // capture the final winner on the same edge that steps the last index.
    assign cand     = snap_reg[scan_idx_reg];
    assign take     = cand > best_val_reg;
    assign best_idx = take ? scan_idx_reg : best_idx_reg;
    assign best_val = take ? cand : best_val_reg;
    assign last     = (scan_idx_reg == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snap_reg[i] <= '0;
            end
            scan_idx_reg <= '0;
            best_idx_reg <= '0;
            best_val_reg <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snap_reg[i] <= pred_word[i];
            end
            scan_idx_reg <= 4'd1;
            best_idx_reg <= '0;
            best_val_reg <= pred_word[0];
        end else if (step) begin
            best_idx_reg <= best_idx;
            best_val_reg <= best_val;
            if (!last) begin
                scan_idx_reg <= scan_idx_reg + 4'd1;
            end
        end
    end
endmodule

// File: rtl/cnn_inference_ctrl.sv
// Host-side request controller: start pulse, bounded wait for done, argmax scan,
// and a valid/ready result port carrying class, score, timeout flag and latency.
module cnn_inference_ctrl #(
    parameter int DATA_WIDTH     = cnn_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES    = cnn_pkg::NUM_CLASSES,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    output logic                              acc_start,
    input  logic                              acc_done,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] acc_predictions,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [3:0]                        result_class,
    output logic signed [DATA_WIDTH-1:0]      result_score,
    output logic                              result_timeout,
    output logic [31:0]                       result_latency
);
    import cnn_pkg::*;

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    ctrl_state_t                  state_reg;
    logic [31:0]                  lat_cnt_reg;
    logic [31:0]                  lat_inc;
    logic                         scan_load;
    logic                         scan_step;
    logic                         scan_last;
    logic [3:0]                   scan_best_idx;
    logic signed [DATA_WIDTH-1:0] scan_best_val;

    // Held low for as long as reset is asserted, not just until the next edge.
    assign req_ready = (state_reg == IDLE) && !reset;
    assign lat_inc   = (lat_cnt_reg == '1) ? lat_cnt_reg : lat_cnt_reg + 32'd1;
    assign scan_load = (state_reg == WAIT) && acc_done;
    assign scan_step = (state_reg == SCAN);

    cnn_argmax_seq #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_argmax (
        .clk         (clk),
        .reset       (reset),
        .load        (scan_load),
        .step        (scan_step),
        .predictions (acc_predictions),
        .last        (scan_last),
        .best_idx    (scan_best_idx),
        .best_val    (scan_best_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= '0;
            acc_start      <= 1'b0;
            result_valid   <= 1'b0;
            result_class   <= '0;
            result_score   <= '0;
            result_timeout <= 1'b0;
            result_latency <= '0;
        end else begin
            acc_start <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        acc_start <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    lat_cnt_reg    <= '0;
                    result_timeout <= 1'b0;
                    state_reg      <= WAIT;
                end
                WAIT: begin
                    lat_cnt_reg <= lat_inc;
                    // Done is checked first so it wins a same-cycle timeout.
                    if (acc_done) begin
                        state_reg <= SCAN;
                    end else if (lat_inc == TIMEOUT_LIMIT) begin
                        result_valid   <= 1'b1;
                        result_timeout <= 1'b1;
                        result_class   <= '0;
                        result_score   <= '0;
                        result_latency <= lat_inc;
                        state_reg      <= HOLD;
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        result_valid   <= 1'b1;
                        result_class   <= scan_best_idx;
                        result_score   <= scan_best_val;
                        result_latency <= lat_cnt_reg;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_inference_ctrl.sv
// Directed bench for cnn_inference_ctrl with hand-computed argmax results.
module tb_cnn_inference_ctrl;
    localparam int DW = 16;
    localparam int NC = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              acc_start;
    logic              acc_done = 1'b0;
    logic [NC*DW-1:0]  acc_predictions;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic [3:0]        result_class;
    logic signed [DW-1:0] result_score;
    logic              result_timeout;
    logic [31:0]       result_latency;

    logic signed [DW-1:0] pv [NC];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        acc_predictions = '0;
        for (int i = 0; i < NC; i++) begin
            acc_predictions[i*DW +: DW] = pv[i];
        end
    end

    cnn_inference_ctrl #(
        .DATA_WIDTH     (DW),
        .NUM_CLASSES    (NC),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .acc_start       (acc_start),
        .acc_done        (acc_done),
        .acc_predictions (acc_predictions),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_class    (result_class),
        .result_score    (result_score),
        .result_timeout  (result_timeout),
        .result_latency  (result_latency)
    );

    // Request, then acc_done during the given WAIT cycle; returns at the negedge after the done edge.
    task automatic run_req(input int done_cycle);
        @(negedge clk); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        repeat (done_cycle - 1) @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk); acc_done = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (result_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            failures++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready);
        end
        checks++;
        if ({acc_start, result_valid, result_timeout} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {acc_start, result_valid, result_timeout});
        end
        checks++;
        if (result_class !== 4'd0 || result_score !== 16'sd0 || result_latency !== 32'd0) begin
            failures++; $display("FAIL reset_result got=%0d/%0d/%0d exp=0/0/0", result_class, result_score, result_latency);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL idle_req_ready got=%0b exp=1", req_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_ascending();
        int n;
        for (int i = 0; i < NC; i++) pv[i] = 16'(i * 256);
        @(negedge clk); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        checks++;
        if (acc_start !== 1'b1 || req_ready !== 1'b0) begin
            failures++; $display("FAIL start_pulse got=%0b/%0b exp=1/0", acc_start, req_ready);
        end
        @(negedge clk);
        checks++;
        if (acc_start !== 1'b0) begin
            failures++; $display("FAIL start_single got=%0b exp=0", acc_start);
        end
        repeat (19) @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk); acc_done = 1'b0;
        wait_valid(n);
        checks++;
        if (n != 9) begin
            failures++; $display("FAIL asc_valid_delay got=%0d exp=9", n);
        end
        checks++;
        if (result_class !== 4'd9 || result_score !== 16'sh0900) begin
            failures++; $display("FAIL asc_result got=%0d/%h exp=9/0900", result_class, result_score);
        end
        checks++;
        if (result_latency !== 32'd20 || result_timeout !== 1'b0) begin
            failures++; $display("FAIL asc_latency got=%0d/%0b exp=20/0", result_latency, result_timeout);
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL asc_handshake got=%0b/%0b exp=0/1", result_valid, req_ready);
        end
        $display("test_ascending class=%0d score=%h latency=%0d", result_class, result_score, result_latency);
    endtask

    task automatic test_tie();
        int n;
        for (int i = 0; i < NC; i++) pv[i] = -16'sd5;
        pv[3] = 16'sd100;
        pv[7] = 16'sd100;
        run_req(5);
        wait_valid(n);
        checks++;
        if (n != 9 || result_class !== 4'd3 || result_score !== 16'sd100) begin
            failures++; $display("FAIL tie got=%0d/%0d(n=%0d) exp=3/100", result_class, result_score, n);
        end
        accept();
        $display("test_tie class=%0d score=%0d", result_class, result_score);
    endtask

    task automatic test_timeout();
        @(negedge clk); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        repeat (63) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_early got=%0b exp=0", result_valid);
        end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || result_timeout !== 1'b1) begin
            failures++; $display("FAIL timeout_flag got=%0b/%0b exp=1/1", result_valid, result_timeout);
        end
        checks++;
        if (result_class !== 4'd0 || result_score !== 16'sd0 || result_latency !== 32'd64) begin
            failures++; $display("FAIL timeout_result got=%0d/%0d/%0d exp=0/0/64", result_class, result_score, result_latency);
        end
        accept();
        $display("test_timeout timeout=%0b latency=%0d", result_timeout, result_latency);
    endtask

    task automatic test_done_at_limit();
        int n;
        for (int i = 0; i < NC; i++) pv[i] = 16'(i);
        pv[6] = 16'sd50;
        run_req(64);
        wait_valid(n);
        checks++;
        if (n != 9 || result_timeout !== 1'b0 || result_latency !== 32'd64) begin
            failures++; $display("FAIL done_wins got=%0b/%0d(n=%0d) exp=0/64", result_timeout, result_latency, n);
        end
        checks++;
        if (result_class !== 4'd6 || result_score !== 16'sd50) begin
            failures++; $display("FAIL done_wins_result got=%0d/%0d exp=6/50", result_class, result_score);
        end
        accept();
        $display("test_done_at_limit class=%0d latency=%0d", result_class, result_latency);
    endtask

    task automatic test_all_negative();
        int n;
        for (int i = 0; i < NC; i++) pv[i] = 16'(-100 - i);
        run_req(3);
        wait_valid(n);
        checks++;
        if (n != 9 || result_class !== 4'd0 || result_score !== -16'sd100) begin
            failures++; $display("FAIL all_negative got=%0d/%0d(n=%0d) exp=0/-100", result_class, result_score, n);
        end
        accept();
        $display("test_all_negative class=%0d score=%0d", result_class, result_score);
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < NC; i++) pv[i] = 16'(10 * i);
        pv[5] = 16'sd500;
        run_req(2);
        for (int i = 0; i < NC; i++) pv[i] = 16'sh7000;
        wait_valid(n);
        checks++;
        if (n != 9 || result_class !== 4'd5 || result_score !== 16'sd500 || result_latency !== 32'd2) begin
            failures++; $display("FAIL bp_result got=%0d/%0d/%0d(n=%0d) exp=5/500/2", result_class, result_score, result_latency, n);
        end
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b1 || result_class !== 4'd5 || result_score !== 16'sd500 ||
                result_latency !== 32'd2 || req_ready !== 1'b0 || acc_start !== 1'b0) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=%0b/%0d/%0d/%0d/%0b exp=1/5/500/2/0",
                                     c, result_valid, result_class, result_score, result_latency, req_ready);
            end
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || acc_start !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL bp_after_hs got=%0b/%0b/%0b exp=0/0/1", result_valid, acc_start, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (acc_start !== 1'b1) begin
            failures++; $display("FAIL bp_next_accept got=%0b exp=1", acc_start);
        end
        for (int i = 0; i < NC; i++) pv[i] = 16'(i);
        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk); acc_done = 1'b0;
        wait_valid(n);
        checks++;
        if (n != 9 || result_class !== 4'd9 || result_latency !== 32'd1) begin
            failures++; $display("FAIL bp_second got=%0d/%0d(n=%0d) exp=9/1", result_class, result_latency, n);
        end
        accept();
        $display("test_backpressure class=%0d latency=%0d", result_class, result_latency);
    endtask

    task automatic test_reset_mid_scan();
        int n;
        for (int i = 0; i < NC; i++) pv[i] = 16'sd20;
        pv[4] = 16'sd70;
        run_req(4);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || result_valid !== 1'b0 || acc_start !== 1'b0 || result_timeout !== 1'b0) begin
            failures++; $display("FAIL rst_mid_flags got=%0b/%0b/%0b/%0b exp=0/0/0/0", req_ready, result_valid, acc_start, result_timeout);
        end
        checks++;
        if (result_class !== 4'd0 || result_score !== 16'sd0 || result_latency !== 32'd0) begin
            failures++; $display("FAIL rst_mid_result got=%0d/%0d/%0d exp=0/0/0", result_class, result_score, result_latency);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (acc_start !== 1'b0 || result_valid !== 1'b0) begin
                failures++; $display("FAIL rst_no_reissue cyc=%0d got=%0b/%0b exp=0/0", c, acc_start, result_valid);
            end
        end
        pv[0] = 16'sd3;  pv[1] = -16'sd1; pv[2] = 16'sd7;  pv[3] = 16'sd7;  pv[4] = 16'sd2;
        pv[5] = 16'sd0;  pv[6] = -16'sd8; pv[7] = 16'sd1;  pv[8] = 16'sd9;  pv[9] = 16'sd9;
        run_req(1);
        wait_valid(n);
        checks++;
        if (n != 9 || result_class !== 4'd8 || result_score !== 16'sd9 || result_latency !== 32'd1) begin
            failures++; $display("FAIL rst_recover got=%0d/%0d/%0d(n=%0d) exp=8/9/1", result_class, result_score, result_latency, n);
        end
        accept();
        $display("test_reset_mid_scan class=%0d score=%0d", result_class, result_score);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) pv[i] = '0;
        test_reset();
        test_ascending();
        test_tie();
        test_timeout();
        test_done_at_limit();
        test_all_negative();
        test_backpressure();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cnn_inference_ctrl.md
# cnn_inference_ctrl

Host-side initiator for the CNN accelerator. It accepts an inference request, issues a one-cycle `start` pulse, waits for `done` with a timeout, and snapshots the 10 signed prediction scores. It then runs a serial argmax over the snapshot and presents the winning class, its score and the measured accelerator latency on a valid/ready result port. It sits between the system request source and the accelerator's `start`/`done`/`predictions` interface.

## Interface
Parameters:
- `DATA_WIDTH`, 16: prediction word width, signed Q8.8.
- `NUM_CLASSES`, 10: number of prediction scores.
- `TIMEOUT_CYCLES`, 4096: maximum number of WAIT cycles before the request is abandoned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  inference request.
- `req_ready`  out  1  high only in IDLE.
- `acc_start`  out  1  one-cycle start pulse to the accelerator.
- `acc_done`  in  1  accelerator completion; sampled only in WAIT.
- `acc_predictions`  in  `NUM_CLASSES` x `DATA_WIDTH` signed  accelerator scores; valid in the cycle `acc_done` is high.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  result consumer accept.
- `result_class`  out  4  argmax index.
- `result_score`  out  `DATA_WIDTH` signed  winning score.
- `result_timeout`  out  1  the request timed out; class and score are 0.
- `result_latency`  out  32  number of WAIT cycles for this request.

## Operation
- States, in order: IDLE, START, WAIT, SCAN, HOLD.
- **IDLE:** `req_ready`=1. On `req_valid`&`req_ready`, go to START.
- **START:** `acc_start`=1 for this one cycle; clear the latency counter; go to WAIT.
- **WAIT:**
  - The latency counter increments every cycle.
  - If `acc_done`=1: capture all `acc_predictions` into the snapshot array; initialise best={idx 0, snap[0]}; set scan index=1; go to SCAN.
  - Else, if the counter reaches `TIMEOUT_CYCLES`: go to HOLD with `result_timeout`=1, class=0, score=0.
  - If `acc_done` and the timeout occur in the same cycle, done wins.
- **SCAN:**
  - Compare one snapshot entry per cycle, for indices 1..`NUM_CLASSES`-1.
  - Replace best only on a strict signed greater-than, so ties keep the lowest index.
  - After index `NUM_CLASSES`-1, go to HOLD.
- **HOLD:**
  - `result_valid`=1. `result_class`, `result_score`, `result_timeout` and `result_latency` are held stable until `result_ready`=1.
  - On handshake, go to IDLE. `result_timeout` stays as set until the next START clears it.
- `acc_done` is ignored outside WAIT, including during START.
- The snapshot decouples the result from later changes on `acc_predictions`.
- All comparisons are signed `DATA_WIDTH`. There is no arithmetic widening.
- The latency counter saturates at 2^32-1. This is unreachable with legal `TIMEOUT_CYCLES`.

## Timing
- Reset values: `req_ready`=0 while reset is asserted and 1 after it is released (state IDLE). `acc_start`=0, `result_valid`=0, `result_class`=0, `result_score`=0, `result_timeout`=0, `result_latency`=0, snapshot cleared.
- Request accepted at edge T: `acc_start` is high for exactly the cycle after T.
- `acc_done` sampled high at edge D: `result_valid` is high from edge D+9 (`NUM_CLASSES`-1 SCAN cycles).
- Timeout path: `result_valid` is high from the edge that ends the `TIMEOUT_CYCLES`-th WAIT cycle.
- `req_ready` is 0 in HOLD. A `req_valid` present at the result handshake is accepted no earlier than the following edge.
- Reset asserted in any state: all outputs return to their reset values immediately (asynchronous). A pending request is dropped and no `acc_start` is reissued.

## Structure
- Shared package `cnn_pkg` holds `DATA_WIDTH`, `FRAC_WIDTH`, `NUM_CLASSES`, and the typedef enum `ctrl_state_t` {IDLE, START, WAIT, SCAN, HOLD}.
- One sub-module, `cnn_argmax_seq`:
  - Owns the snapshot registers, scan index and best-so-far.
  - Controls: load, step.
  - Outputs: last, best_idx, best_val.
- The top level owns the FSM, latency counter, timeout compare and result registers.

## Test plan
- **Ascending scores:** `acc_predictions[i]`=i*0x0100; `acc_done` in the 20th WAIT cycle -> class 9, score 0x0900, latency 20, timeout 0.
- **Tie:** all scores -5 except idx 3 and idx 7 = 100 -> class 3, score 100.
- **All negative:** `acc_predictions[i]`=-100-i -> class 0, score -100.
- **Timeout:** `TIMEOUT_CYCLES`=64, `acc_done` never asserted -> timeout 1, class 0, score 0, latency 64.
- **Backpressure:**
  - `result_ready` held low for 5 cycles after `result_valid` rises -> all result outputs stable and `req_ready`=0.
  - With `req_valid` held high, the next request is accepted one cycle after the handshake.
  - `acc_predictions` changing during SCAN does not affect the result.
- **Reset mid-operation:** `reset` pulsed mid-SCAN -> outputs are at their reset values in the same cycle. A subsequent request completes normally with correct argmax.
